// File: rtl/syn_gpu_div_arb.sv
// Round-robin arbiter that shares one 16b/16b divider among NUM_REQ requesters.
// It keeps one divider operation outstanding, routes the result by MID, and aborts the wait on a watchdog timeout.
module syn_gpu_div_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int MID_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        i_clk_ir,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic [NUM_REQ-1:0]          o_rsp_valid,
  output logic [DATA_W-1:0]           o_rsp_data,
  output logic [MID_W-1:0]            o_div_req_mid,
  output logic [DATA_W-1:0]           o_div_req_data,
  input  logic                        i_div_busy,
  input  logic [MID_W-1:0]            i_div_rsp_mid,
  input  logic [DATA_W-1:0]           i_div_rsp_data,
  output logic                        o_arb_busy,
  output logic                        o_err_timeout,
  output logic                        o_err_stray
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [MID_W-1:0] MID_IDLE = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DRAIN
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_gnt_idx;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [TMR_W-1:0]    r_timer;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [MID_W-1:0]    r_div_req_mid;
  logic [DATA_W-1:0]   r_div_req_data;
  logic                r_arb_busy;
  logic                r_err_timeout;
  logic                r_err_stray;

  state_t              w_state_next;
  logic [IDX_W-1:0]    w_gnt_idx_next;
  logic [IDX_W-1:0]    w_rr_ptr_next;
  logic [TMR_W-1:0]    w_timer_next;
  logic [NUM_REQ-1:0]  w_req_ready_next;
  logic [NUM_REQ-1:0]  w_rsp_valid_next;
  logic [DATA_W-1:0]   w_rsp_data_next;
  logic [MID_W-1:0]    w_div_req_mid_next;
  logic [DATA_W-1:0]   w_div_req_data_next;
  logic                w_err_timeout_next;
  logic                w_err_stray_next;

  logic [DATA_W-1:0]   w_req_word [NUM_REQ];
  logic [IDX_W-1:0]    w_sel_idx;
  logic [IDX_W-1:0]    w_rr_adv;
  logic [MID_W-1:0]    w_own_mid;
  logic                w_match;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_word[gi] = i_req_data[gi*DATA_W +: DATA_W];
  end

  // Scan from the highest offset down so the nearest valid requester after rr_ptr wins.
  always_comb begin
    int v;
    v = 0;
    w_sel_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v = int'(r_rr_ptr) + k;
      if (v >= NUM_REQ) v = v - NUM_REQ;
      if (i_req_valid[v[IDX_W-1:0]]) w_sel_idx = v[IDX_W-1:0];
    end
  end

  assign w_own_mid = MID_W'(r_gnt_idx) + MID_W'(1);
  assign w_match   = (r_state == ST_WAIT_RSP) && (i_div_rsp_mid == w_own_mid);
  assign w_rr_adv  = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + IDX_W'(1);

  always_comb begin
    w_state_next        = r_state;
    w_gnt_idx_next      = r_gnt_idx;
    w_rr_ptr_next       = r_rr_ptr;
    w_timer_next        = r_timer;
    w_req_ready_next    = '0;
    w_rsp_valid_next    = '0;
    w_rsp_data_next     = r_rsp_data;
    w_div_req_mid_next  = r_div_req_mid;
    w_div_req_data_next = r_div_req_data;
    w_err_timeout_next  = 1'b0;
    w_err_stray_next    = (i_div_rsp_mid != MID_IDLE) && !w_match;

    case (r_state)
      ST_IDLE: begin
        if ((|i_req_valid) && !i_div_busy) begin
          w_state_next                = ST_ISSUE;
          w_gnt_idx_next              = w_sel_idx;
          w_req_ready_next[w_sel_idx] = 1'b1;
          w_div_req_mid_next          = MID_W'(w_sel_idx) + MID_W'(1);
          w_div_req_data_next         = w_req_word[w_sel_idx];
        end
      end
      ST_ISSUE: begin
        w_state_next       = ST_WAIT_RSP;
        w_div_req_mid_next = MID_IDLE;
        w_timer_next       = '0;
      end
      ST_WAIT_RSP: begin
        w_timer_next = r_timer + TMR_W'(1);
        // A response landing on the final cycle still counts as a normal completion.
        if (w_match) begin
          w_state_next                = ST_IDLE;
          w_rsp_valid_next[r_gnt_idx] = 1'b1;
          w_rsp_data_next             = i_div_rsp_data;
          w_rr_ptr_next               = w_rr_adv;
        end else if (r_timer == TMR_W'(TIMEOUT_CYC - 1)) begin
          w_state_next                = ST_DRAIN;
          w_rsp_valid_next[r_gnt_idx] = 1'b1;
          w_rsp_data_next             = '1;
          w_rr_ptr_next               = w_rr_adv;
          w_err_timeout_next          = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!i_div_busy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_ir) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_gnt_idx      <= '0;
      r_rr_ptr       <= '0;
      r_timer        <= '0;
      r_req_ready    <= '0;
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_div_req_mid  <= MID_IDLE;
      r_div_req_data <= '0;
      r_arb_busy     <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_stray    <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_gnt_idx      <= w_gnt_idx_next;
      r_rr_ptr       <= w_rr_ptr_next;
      r_timer        <= w_timer_next;
      r_req_ready    <= w_req_ready_next;
      r_rsp_valid    <= w_rsp_valid_next;
      r_rsp_data     <= w_rsp_data_next;
      r_div_req_mid  <= w_div_req_mid_next;
      r_div_req_data <= w_div_req_data_next;
      r_arb_busy     <= (w_state_next != ST_IDLE);
      r_err_timeout  <= w_err_timeout_next;
      r_err_stray    <= w_err_stray_next;
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_div_req_mid  = r_div_req_mid;
  assign o_div_req_data = r_div_req_data;
  assign o_arb_busy     = r_arb_busy;
  assign o_err_timeout  = r_err_timeout;
  assign o_err_stray    = r_err_stray;

endmodule

// File: tb/tb_syn_gpu_div_arb.sv
// Bench for syn_gpu_div_arb: directed scenarios plus randomized traffic against a divider model,
// with every output checked each cycle against a transaction-level reference model.
module tb_syn_gpu_div_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic              div_busy;
  logic [MW-1:0]     div_rsp_mid;
  logic [DW-1:0]     div_rsp_data;
  logic [N-1:0]      o_req_ready;
  logic [N-1:0]      o_rsp_valid;
  logic [DW-1:0]     o_rsp_data;
  logic [MW-1:0]     o_div_req_mid;
  logic [DW-1:0]     o_div_req_data;
  logic              o_arb_busy;
  logic              o_err_timeout;
  logic              o_err_stray;

  syn_gpu_div_arb #(.NUM_REQ(N), .DATA_W(DW), .MID_W(MW), .TIMEOUT_CYC(TO)) u_dut (
    .i_clk_ir       (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_data     (req_data),
    .o_req_ready    (o_req_ready),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_data     (o_rsp_data),
    .o_div_req_mid  (o_div_req_mid),
    .o_div_req_data (o_div_req_data),
    .i_div_busy     (div_busy),
    .i_div_rsp_mid  (div_rsp_mid),
    .i_div_rsp_data (div_rsp_data),
    .o_arb_busy     (o_arb_busy),
    .o_err_timeout  (o_err_timeout),
    .o_err_stray    (o_err_stray)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an operation is described by its owner and the edge it was granted on.
  int           m_owner = -1;
  int           m_issue_edge = 0;
  int           m_rr = 0;
  bit           m_drain = 0;
  int           edge_n = 0;
  bit           m_rst_seen = 0;
  logic [N-1:0] e_ready, e_rsp_valid;
  logic [DW-1:0] e_rsp_data, e_data;
  logic [MW-1:0] e_mid;
  bit           e_busy, e_to, e_stray;

  task automatic model_step();
    bit waiting, matched, found;
    int g, c, waited;
    edge_n++;
    m_rst_seen = rst;
    if (rst) begin
      m_owner = -1; m_drain = 0; m_rr = 0;
      e_ready = '0; e_rsp_valid = '0; e_rsp_data = '0; e_data = '0; e_mid = '0;
      e_busy = 0; e_to = 0; e_stray = 0;
      return;
    end
    e_ready = '0; e_rsp_valid = '0; e_to = 0;
    waiting = (m_owner >= 0) && (edge_n >= m_issue_edge + 2);
    matched = waiting && (div_rsp_mid == MW'(m_owner + 1));
    e_stray = (div_rsp_mid != '0) && !matched;
    waited  = edge_n - m_issue_edge - 2;
    if (m_drain) begin
      if (!div_busy) m_drain = 0;
    end else if (m_owner < 0) begin
      if (req_valid != '0 && !div_busy) begin
        found = 0; g = 0;
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!found && req_valid[c]) begin g = c; found = 1; end
        end
        m_owner = g; m_issue_edge = edge_n;
        e_ready[g] = 1'b1;
        e_mid = MW'(g + 1);
        e_data = req_data[g*DW +: DW];
      end
    end else if (!waiting) begin
      e_mid = '0;
    end else if (matched) begin
      e_rsp_valid[m_owner] = 1'b1;
      e_rsp_data = div_rsp_data;
      m_rr = (m_owner + 1) % N;
      m_owner = -1;
    end else if (waited == TO - 1) begin
      e_rsp_valid[m_owner] = 1'b1;
      e_rsp_data = '1;
      e_to = 1;
      m_rr = (m_owner + 1) % N;
      m_owner = -1;
      m_drain = 1;
    end
    e_busy = (m_owner >= 0) || m_drain;
  endtask

  task automatic compare_all();
    check("req_ready", o_req_ready, e_ready);
    check("rsp_valid", o_rsp_valid, e_rsp_valid);
    if (e_rsp_valid != '0 || m_rst_seen) check("rsp_data", o_rsp_data, e_rsp_data);
    check("div_req_mid", o_div_req_mid, e_mid);
    if (e_mid != '0 || m_rst_seen) check("div_req_data", o_div_req_data, e_data);
    check("arb_busy", o_arb_busy, e_busy);
    check("err_timeout", o_err_timeout, e_to);
    check("err_stray", o_err_stray, e_stray);
  endtask

  // Stimulus agents: requesters and a divider that computes real quotients.
  int   req_mode = 0;   // 0 manual, 1 random, 2 all held valid
  int   dv_mode  = 0;   // 0 manual, 1 automatic divider
  bit   dv_chaos = 0;
  bit   rand_rst = 0;
  bit   dv_pending = 0, dv_silent = 0;
  int   dv_cnt = 0;
  logic [MW-1:0] dv_mid;
  logic [DW-1:0] dv_res;
  int   grant_q[$];

  function automatic logic [DW-1:0] rand_op();
    logic [15:0] a, b;
    a = 16'($urandom_range(0, 65535));
    b = 16'($urandom_range(1, 65535));
    return {a, b};
  endfunction

  task automatic drive_auto();
    logic [15:0] a, b;
    if (req_mode == 2) begin
      for (int i = 0; i < N; i++)
        if (o_req_ready[i]) req_data[i*DW +: DW] = rand_op();
      req_valid = '1;
    end else if (req_mode == 1) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && o_req_ready[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = rand_op();
        end
      end
    end
    if (dv_mode == 1) begin
      div_rsp_mid = '0;
      if (dv_pending) begin
        if (dv_cnt == 0) begin
          if (!dv_silent) begin div_rsp_mid = dv_mid; div_rsp_data = dv_res; end
          dv_pending = 0; div_busy = 1'b0;
        end else dv_cnt--;
      end else if (o_div_req_mid != '0) begin
        a = o_div_req_data[31:16]; b = o_div_req_data[15:0];
        dv_res = (b != 0) ? {a / b, a % b} : {16'hFFFF, a};
        dv_mid = o_div_req_mid;
        dv_silent = dv_chaos && ($urandom_range(0, 7) == 0);
        dv_cnt = dv_silent ? $urandom_range(40, 90) : $urandom_range(0, 12);
        dv_pending = 1; div_busy = 1'b1;
      end else if (dv_chaos && $urandom_range(0, 30) == 0) begin
        div_rsp_mid = MW'($urandom_range(1, 15));
        div_rsp_data = $urandom;
      end
    end
    if (rand_rst) rst = ($urandom_range(0, 299) == 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
    model_step();
    compare_all();
    for (int i = 0; i < N; i++) if (o_req_ready[i]) grant_q.push_back(i);
    if (o_rsp_valid != '0)
      $display("txn t=%0t rsp_valid=%b rsp_data=%h err_timeout=%0b", $time, o_rsp_valid, o_rsp_data, o_err_timeout);
    drive_auto();
  endtask

  initial begin
    int cnt;
    bit found;
    rst = 1'b1; req_valid = '0; req_data = '0; div_busy = 1'b0;
    div_rsp_mid = '0; div_rsp_data = '0;
    tick(); tick();
    check("rst_arb_busy", o_arb_busy, 0);
    check("rst_mid", o_div_req_mid, 0);
    rst = 1'b0;
    tick();

    // Single request from requester 2.
    req_valid = 4'b0100; req_data[2*DW +: DW] = 32'h0064_0007;
    tick();
    check("t1_ready", o_req_ready, 4'b0100);
    check("t1_mid", o_div_req_mid, 3);
    check("t1_data", o_div_req_data, 32'h0064_0007);
    req_valid = '0; div_busy = 1'b1;
    tick(); tick(); tick();
    div_rsp_mid = 3; div_rsp_data = 32'h000E_0002; div_busy = 1'b0;
    tick();
    check("t1_rsp_valid", o_rsp_valid, 4'b0100);
    check("t1_rsp_data", o_rsp_data, 32'h000E_0002);
    div_rsp_mid = '0;
    tick();

    // All requesters held valid from reset: grants rotate 0,1,2,3,0.
    rst = 1'b1; tick(); rst = 1'b0;
    grant_q.delete();
    req_mode = 2; dv_mode = 1; dv_chaos = 0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rand_op();
    req_valid = '1;
    for (int i = 0; i < 400 && grant_q.size() < 5; i++) tick();
    check("t2_ngrants", grant_q.size() >= 5, 1);
    for (int j = 0; j < 5 && j < grant_q.size(); j++) check("t2_order", grant_q[j], j % N);
    req_mode = 0; req_valid = '0;
    for (int i = 0; i < 60 && (o_arb_busy || dv_pending); i++) tick();
    check("t2_settle", o_arb_busy, 0);
    dv_mode = 0; div_busy = 1'b0; div_rsp_mid = '0;
    tick();

    // Divider never answers: watchdog abort, then DRAIN until div_busy falls.
    req_valid = 4'b0010; req_data[1*DW +: DW] = 32'h0050_0003;
    tick();
    check("t3_ready", o_req_ready, 4'b0010);
    req_valid = '0; div_busy = 1'b1;
    cnt = 0; found = 0;
    for (int i = 0; i < 200; i++) begin
      tick(); cnt++;
      if (o_err_timeout) begin found = 1; break; end
    end
    check("t3_timeout_seen", found, 1);
    check("t3_latency", cnt, TO + 1);
    check("t3_rsp_valid", o_rsp_valid, 4'b0010);
    check("t3_rsp_data", o_rsp_data, 32'hFFFF_FFFF);
    repeat (5) tick();
    check("t3_drain_busy", o_arb_busy, 1);
    div_busy = 1'b0;
    tick();
    check("t3_idle", o_arb_busy, 0);

    // Stray MID 4 while waiting on MID 2, then the real response.
    req_valid = 4'b0010; req_data[1*DW +: DW] = 32'h0009_0002;
    tick();
    check("t4_ready", o_req_ready, 4'b0010);
    req_valid = '0;
    tick();
    div_rsp_mid = 4; div_rsp_data = 32'hDEAD_BEEF;
    tick();
    check("t4_stray", o_err_stray, 1);
    check("t4_no_rsp", o_rsp_valid, 0);
    div_rsp_mid = '0;
    tick();
    check("t4_stray_clear", o_err_stray, 0);
    div_rsp_mid = 2; div_rsp_data = 32'h0004_0001;
    tick();
    check("t4_rsp_valid", o_rsp_valid, 4'b0010);
    check("t4_rsp_data", o_rsp_data, 32'h0004_0001);
    div_rsp_mid = '0;
    tick();

    // Response arrives on the timeout cycle: normal completion wins.
    req_valid = 4'b0001; req_data[0 +: DW] = 32'h1234_0005;
    tick();
    req_valid = '0;
    repeat (TO) tick();
    div_rsp_mid = 1; div_rsp_data = 32'h03A4_0000;
    tick();
    check("t5_rsp_valid", o_rsp_valid, 4'b0001);
    check("t5_rsp_data", o_rsp_data, 32'h03A4_0000);
    check("t5_no_timeout", o_err_timeout, 0);
    div_rsp_mid = '0;
    tick();

    // Reset during WAIT_RSP, late response is stray, next grant starts from pointer 0.
    req_valid = 4'b0100; req_data[2*DW +: DW] = 32'h0010_0004;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_rst_busy", o_arb_busy, 0);
    check("t6_rst_rsp", o_rsp_valid, 0);
    rst = 1'b0; div_rsp_mid = 3; div_rsp_data = 32'h0004_0000;
    tick();
    check("t6_late_stray", o_err_stray, 1);
    check("t6_late_no_rsp", o_rsp_valid, 0);
    div_rsp_mid = '0;
    req_valid = 4'b1001; req_data[0 +: DW] = 32'h0001_0001; req_data[3*DW +: DW] = 32'h0002_0001;
    tick();
    check("t6_ready_from0", o_req_ready, 4'b0001);
    req_valid = 4'b1000;
    tick();
    div_rsp_mid = 1; div_rsp_data = 32'h0001_0000;
    tick();
    div_rsp_mid = '0; req_valid = '0;
    repeat (8) tick();

    // Randomized traffic with silent divider ops, strays and occasional resets.
    div_busy = 1'b0; dv_pending = 0;
    req_mode = 1; dv_mode = 1; dv_chaos = 1; rand_rst = 1;
    repeat (6000) tick();
    rand_rst = 0; rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/syn_gpu_div_arb.md
Name: syn_gpu_div_arb

Overview:
Arbiter/sequencer that shares the single GPU 16b/16b divider among NUM_REQ requesters.
- Owns the master side of the mulberry divider channel: div_req_mid, div_req_data, div_busy, div_rsp_mid, div_rsp_data.
- Grants requesters round-robin and issues one request at a time.
- Tracks the outstanding MID and routes quotient/remainder back to the owning requester.
- A watchdog recovers the channel if a response never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, request/response width; upper 16b dividend/quotient, lower 16b divisor/remainder
MID_W, 4, MID field width; MID_IDLE = 0, requester i uses MID i+1
TIMEOUT_CYC, 64, max cycles in WAIT_RSP before abort

Ports:
clk_ir  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request; held until req_ready
req_data  in  NUM_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
rsp_valid  out  NUM_REQ  one-cycle response pulse, one-hot
rsp_data  out  DATA_W  {quotient, remainder}; valid with rsp_valid
div_req_mid  out  MID_W  MID to divider; MID_IDLE when no request
div_req_data  out  DATA_W  {dividend, divisor} to divider
div_busy  in  1  divider busy
div_rsp_mid  in  MID_W  divider response MID; non-idle for one cycle
div_rsp_data  in  DATA_W  divider {q, r}
arb_busy  out  1  high in any state except IDLE
err_timeout  out  1  one-cycle pulse on watchdog abort
err_stray  out  1  one-cycle pulse on unexpected non-idle div_rsp_mid

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, div_req_mid=MID_IDLE, div_req_data=0, arb_busy=0, err_*=0, state=IDLE, rr_ptr=0, timer=0, gnt_idx=0.
- FSM states: IDLE, ISSUE, WAIT_RSP, DRAIN.
- IDLE:
  - Enabled when (|req_valid) & ~div_busy.
  - Select the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ; store it in gnt_idx.
  - Next edge: state=ISSUE, div_req_mid=gnt_idx+1, div_req_data=req_data[gnt_idx], req_ready[gnt_idx]=1.
- ISSUE (exactly 1 cycle): next edge: div_req_mid=MID_IDLE, req_ready=0, timer=0, state=WAIT_RSP.
- Request latency: req_valid sampled in IDLE -> req_ready and div_req_mid asserted 1 cycle later.
- The requester may drop req_valid/req_data after the req_ready cycle. Dropping req_valid before req_ready is a protocol violation with undefined result.
- WAIT_RSP:
  - timer increments each cycle.
  - If div_rsp_mid == gnt_idx+1: next edge rsp_valid[gnt_idx]=1, rsp_data=div_rsp_data, rr_ptr=(gnt_idx+1) mod NUM_REQ, state=IDLE.
  - Response latency: div_rsp_mid match -> rsp_valid 1 cycle later.
  - Else if timer == TIMEOUT_CYC-1: next edge err_timeout=1, rsp_valid[gnt_idx]=1, rsp_data = all ones, rr_ptr advances, state=DRAIN.
  - A match and a timeout in the same cycle: the match wins; no error.
- DRAIN: stay until div_busy==0, then go to IDLE. Any non-idle div_rsp_mid seen in DRAIN is discarded with no rsp_valid.
- err_stray: pulses the cycle after any non-idle div_rsp_mid that is not a match in WAIT_RSP, including in IDLE/ISSUE/DRAIN and after reset.
- Only one divider operation is outstanding at a time. New requests, including one from the current owner, wait until IDLE.
- Fairness: the last-served requester becomes lowest priority. With all requesters active, grants rotate 0,1,2,3,0...
- Reset mid-operation: return to IDLE with reset values next edge; outstanding request lost, no rsp_valid generated.
- Minimum back-to-back throughput: 3 cycles + divider latency per operation.
- The divider must be idle (div_busy=0) before any issue. A div_busy high from elsewhere stalls the grant.

Test Plan:
- Single request: req_valid[2], data 0x0064_0007 -> req_ready[2] next cycle with div_req_mid=3, div_req_data=0x00640007. Divider returns mid 3 with {0x000E,0x0002} -> rsp_valid[2], rsp_data=0x000E0002 one cycle later.
- All four requesters held valid from reset -> grant order 0,1,2,3,0. Each rsp_valid is one-hot and matches its MID; never two outstanding.
- Divider model never responds -> err_timeout pulse and rsp_valid[gnt] with rsp_data=0xFFFFFFFF at TIMEOUT_CYC. State stays DRAIN while div_busy=1, then returns to IDLE when div_busy=0.
- div_rsp_mid=4 while waiting on MID 2 -> err_stray pulse, no rsp_valid. The later MID 2 response completes normally.
- Response exactly on the timeout cycle -> normal rsp_valid with divider data, err_timeout stays 0.
- rst asserted in WAIT_RSP -> all outputs at reset values next cycle. A late div_rsp_mid then gives err_stray only, and a fresh request is serviced from rr_ptr=0.
